// File: rtl/circuit_bist.sv
// circuit_bist: LFSR stimulus generator and MISR response compactor for the circuit datapath
module circuit_bist #(
  parameter int W = 32,
  parameter int N_VEC = 100,
  parameter int WARMUP = 10,
  parameter int LAT = 1,
  parameter logic [W-1:0] POLY = W'(32'hA3000000)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  output logic         dut_en,
  output logic [W-1:0] dut_x,
  input  logic [W-1:0] dut_y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] signature,
  output logic [15:0]  vec_cnt
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WARM  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state, state_nx;
  logic [W-1:0]   lfsr, seed_eff, src, misr_nx;
  logic [LAT-1:0] pipe;
  logic [31:0]    cnt, issued;
  logic           accept, warm_last, run_end, drain_last, issue, cnt_inc;

  function automatic logic [W-1:0] step(input logic [W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : '0);
  endfunction

  assign accept     = start && (state == S_IDLE || state == S_DONE);
  assign seed_eff   = (seed == '0) ? W'(1) : seed;
  assign src        = accept ? seed_eff : lfsr;
  assign warm_last  = state == S_WARM && cnt == 32'(WARMUP - 1);
  assign run_end    = state == S_RUN && issued >= 32'(N_VEC);
  assign drain_last = state == S_DRAIN && cnt == 32'(LAT - 1);
  assign issue      = (accept && WARMUP == 0) || warm_last || (state == S_RUN && issued < 32'(N_VEC));
  assign cnt_inc    = (state == S_WARM && !warm_last) || (state == S_DRAIN && !drain_last);
  assign misr_nx    = step(signature) ^ dut_y;

  // Next-state selection; a start in DONE behaves exactly like one in IDLE
  always_comb begin
    state_nx = accept ? (WARMUP == 0 ? S_RUN : S_WARM) :
               warm_last  ? S_RUN   :
               run_end    ? S_DRAIN :
               drain_last ? S_DONE  : state;
  end

  // Control state: FSM, phase counter, run bookkeeping and handshake flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      issued  <= '0;
      vec_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= (accept || run_end) ? '0 : cnt_inc ? cnt + 32'd1 : cnt;
      issued  <= accept ? (issue ? 32'd1 : 32'd0) : issue ? issued + 32'd1 : issued;
      vec_cnt <= accept ? (issue ? 16'd1 : 16'd0) :
                 (issue && vec_cnt != 16'hFFFF) ? vec_cnt + 16'd1 : vec_cnt;
      busy    <= accept ? 1'b1 : drain_last ? 1'b0 : busy;
      done    <= accept ? 1'b0 : drain_last ? 1'b1 : done;
    end
  end

  // Stimulus side: the vector issued is the pre-advance LFSR value, so the first equals the seed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr   <= '0;
      dut_en <= 1'b0;
      dut_x  <= '0;
    end else begin
      lfsr   <= issue ? step(src) : accept ? seed_eff : lfsr;
      dut_en <= issue;
      dut_x  <= issue ? src : dut_x;
    end
  end

  // Response side: dut_en delayed by LAT marks the edge where dut_y belongs to an issued vector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe      <= '0;
      signature <= '0;
    end else begin
      pipe      <= LAT'({pipe, dut_en});
      signature <= accept ? '0 : pipe[LAT-1] ? misr_nx : signature;
    end
  end
endmodule

// File: tb/tb_circuit_bist.sv
// tb_circuit_bist: randomized self-check of circuit_bist against a vector-list/MISR model
module tb_circuit_bist;
  localparam logic [31:0] POLY = 32'hA3000000;
  localparam int NA = 4, WA = 2, LA = 1;
  localparam int NB = 100, WB = 3, LB = 3;

  logic        clk = 0, rst = 0;
  logic        start_a = 0, start_b = 0, ff_a = 0;
  logic [31:0] seed_a = 0, seed_b = 0, mask_a = 0, mask_b = 0;
  logic        en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] x_a, x_b, y_a, y_b, sig_a, sig_b, s1, s2;
  logic [15:0] cnt_a, cnt_b;
  logic [31:0] obs_x[$];
  logic [31:0] obs_sig;
  logic [15:0] obs_cnt;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  circuit_bist #(.W(32), .N_VEC(NA), .WARMUP(WA), .LAT(LA), .POLY(POLY)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .dut_en(en_a), .dut_x(x_a),
    .dut_y(y_a), .busy(busy_a), .done(done_a), .signature(sig_a), .vec_cnt(cnt_a));

  circuit_bist #(.W(32), .N_VEC(NB), .WARMUP(WB), .LAT(LB), .POLY(POLY)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .dut_en(en_b), .dut_x(x_b),
    .dut_y(y_b), .busy(busy_b), .done(done_b), .signature(sig_b), .vec_cnt(cnt_b));

  // DUT stubs: one-stage register for u_a, three-stage delay for u_b
  always @(posedge clk) y_a <= ff_a ? 32'hFFFFFFFF : x_a ^ mask_a;
  always @(posedge clk) begin
    s1  <= x_b;
    s2  <= s1;
    y_b <= s2 ^ mask_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  // One complete run: request, observe every cycle until done, then compare with the model
  task automatic run(input bit b, input logic [31:0] sd, input logic [31:0] mk, input bit ff, input int pulse_at);
    int nv, wu, lat, c, bad, done_at;
    logic [31:0] l, sig, y;
    logic [31:0] ex[$];
    nv = b ? NB : NA;
    wu = b ? WB : WA;
    lat = b ? LB : LA;
    if (b) begin seed_b = sd; mask_b = mk; start_b = 1; end
    else begin seed_a = sd; mask_a = mk; ff_a = ff; start_a = 1; end
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    chk("acc_busy", b ? busy_b : busy_a, 1);
    chk("acc_done", b ? done_b : done_a, 0);
    chk("acc_sig", b ? sig_b : sig_a, 0);
    obs_x.delete();
    bad = 0;
    done_at = -1;
    c = 0;
    while (c < wu + nv + lat + 20) begin
      bit e, d, bs;
      e = b ? en_b : en_a;
      d = b ? done_b : done_a;
      bs = b ? busy_b : busy_a;
      if (e) obs_x.push_back(b ? x_b : x_a);
      if (e != (c >= wu && c < wu + nv)) bad++;
      if ((b ? cnt_b : cnt_a) != 16'(obs_x.size())) bad++;
      if (d) begin
        if (bs) bad++;
        done_at = c;
        break;
      end
      if (!bs) bad++;
      if (b) start_b = (c == pulse_at); else start_a = (c == pulse_at);
      @(negedge clk);
      c++;
    end
    start_a = 0;
    start_b = 0;
    l = (sd == 0) ? 32'd1 : sd;
    sig = 0;
    for (int i = 0; i < nv; i++) begin
      ex.push_back(l);
      y = ff ? 32'hFFFFFFFF : l ^ mk;
      sig = lstep(sig) ^ y;
      l = lstep(l);
    end
    obs_sig = b ? sig_b : sig_a;
    obs_cnt = b ? cnt_b : cnt_a;
    chk("en_count", obs_x.size(), nv);
    chk("en_busy_cnt_pattern", bad, 0);
    chk("done_cycle", done_at, wu + nv + lat);
    chk("vec_cnt", obs_cnt, nv);
    chk("signature", obs_sig, sig);
    for (int i = 0; i < nv; i++)
      chk("dut_x", i < obs_x.size() ? obs_x[i] : ~ex[i], ex[i]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", {en_a, en_b}, 0);
    chk("rst_x", x_a | x_b, 0);
    chk("rst_busy_done", {busy_a, busy_b, done_a, done_b}, 0);
    chk("rst_sig", sig_a | sig_b, 0);
    chk("rst_cnt", cnt_a | cnt_b, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy_a, 0);

    run(0, 32'h1, 32'h0, 0, -1);
    chk("p1_x0", obs_x[0], 32'h00000001);
    chk("p1_x1", obs_x[1], 32'hA3000000);
    chk("p1_x2", obs_x[2], 32'h51800000);
    chk("p1_x3", obs_x[3], 32'h28C00000);
    chk("p1_sig", obs_sig, 32'h0);

    run(0, 32'h1, 32'h0, 1, -1);
    chk("p2_sig", obs_sig, 32'h2BC00000);
    chk("p2_cnt", obs_cnt, 4);
    repeat (3) @(negedge clk);
    chk("hold_done", done_a, 1);
    chk("hold_busy", busy_a, 0);
    chk("hold_sig", sig_a, 32'h2BC00000);

    run(0, 32'h0, 32'h0, 0, -1);
    chk("zero_seed_x0", obs_x[0], 32'h1);

    run(0, 32'hA3000000, 32'h0, 0, -1);
    chk("seedA3_x0", obs_x[0], 32'hA3000000);
    chk("seedA3_x1", obs_x[1], 32'h51800000);
    chk("seedA3_x2", obs_x[2], 32'h28C00000);

    run(0, $urandom, $urandom | 32'h1, 0, WA + 2);
    run(0, $urandom, $urandom | 32'h1, 0, -1);
    repeat (6) run(0, $urandom, $urandom, 1'($urandom_range(0, 1)), -1);

    run(1, 32'h1, 32'h0, 0, -1);
    run(1, $urandom, $urandom, 0, -1);

    start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (WA + 2) @(negedge clk);
    chk("mid_run_en", en_a, 1);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("async_en", {en_a, en_b}, 0);
    chk("async_x", x_a | x_b, 0);
    chk("async_busy_done", {busy_a, busy_b, done_a, done_b}, 0);
    chk("async_sig", sig_a | sig_b, 0);
    chk("async_cnt", cnt_a | cnt_b, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {en_a, busy_a, done_a}, 0);
    run(0, 32'h1, 32'h0, 0, -1);
    chk("post_rst_sig", obs_sig, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
